array_reverse: RTL and testbench

- Initiator (master) for the single-port array memory interface: async read data, sync write, valid/ready handshake.
- Accepts a command {lo, hi} and reverses the array region [lo..hi] in place by pairwise swaps.
- Returns the number of swaps performed on a result handshake.
- Sits between sequencing logic and an array instance; first consumer of the array port that drives addresses itself.

---
 rtl/array_reverse.sv | 188 ++++++++++++++++++
 tb/tb_array_reverse.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_reverse.sv
// array_reverse
//   Reverses a region [lo..hi] of an external single-port array in place by
//   pairwise swaps. The array is read combinationally (arr_do follows
//   arr_addr) and written at the clock edge that completes a request.
//   A request completes in any cycle with arr_valid && arr_ready.
//
//   Optional build macro: ARRAY_REVERSE_SKIP_EQ_EN
//     When defined, a pair whose two values are already equal is not written
//     back and is not counted in out_swaps.
//
// Ports
//   clk, nrst            clock, asynchronous active-low reset
//   in_valid/in_ready    command handshake, in_lo/in_hi = region bounds
//   out_valid/out_ready  result handshake, out_swaps = pairs written
//   arr_valid/arr_ready  array request handshake
//   arr_addr, arr_we     request address, 1 = write / 0 = read
//   arr_di, arr_do       write data, combinational read data
//
// State table
//   IDLE  | waiting for a command, in_ready = 1
//   RD_LO | reading data[lo] into tmp_lo
//   RD_HI | reading data[hi], value goes straight into the write-data register
//   WR_LO | writing old data[hi] to data[lo]
//   WR_HI | writing old data[lo] to data[hi], then advance lo/hi
//   DONE  | presenting out_swaps until out_ready
module array_reverse #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_lo,
    input  logic [AW-1:0] in_hi,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_swaps,
    output logic          arr_valid,
    input  logic          arr_ready,
    output logic [AW-1:0] arr_addr,
    output logic          arr_we,
    output logic [DW-1:0] arr_di,
    input  logic [DW-1:0] arr_do
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic [AW-1:0] swaps;
    logic [DW-1:0] tmp_lo;

    logic [AW-1:0] lo_nxt;
    logic [AW-1:0] hi_nxt;
    logic          more;
    logic          xfer;

    // lo < hi holds whenever these are used, so neither bound can wrap.
    assign lo_nxt = lo + AW'(1);
    assign hi_nxt = hi - AW'(1);
    assign more   = lo_nxt < hi_nxt;
    assign xfer   = arr_valid && arr_ready;

    assign in_ready  = (state == IDLE);
    assign out_swaps = swaps;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            lo        <= '0;
            hi        <= '0;
            swaps     <= '0;
            tmp_lo    <= '0;
            out_valid <= 1'b0;
            arr_valid <= 1'b0;
            arr_addr  <= '0;
            arr_we    <= 1'b0;
            arr_di    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        lo    <= in_lo;
                        hi    <= in_hi;
                        swaps <= '0;
                        if (in_lo < in_hi) begin
                            state     <= RD_LO;
                            arr_valid <= 1'b1;
                            arr_addr  <= in_lo;
                            arr_we    <= 1'b0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end

                RD_LO: begin
                    if (xfer) begin
                        tmp_lo   <= arr_do;
                        state    <= RD_HI;
                        arr_addr <= hi;
                    end
                end

                RD_HI: begin
                    if (xfer) begin
`ifdef ARRAY_REVERSE_SKIP_EQ_EN
                        if (arr_do == tmp_lo) begin
                            // Pair already symmetric: advance without writing.
                            lo <= lo_nxt;
                            hi <= hi_nxt;
                            if (more) begin
                                state    <= RD_LO;
                                arr_addr <= lo_nxt;
                            end else begin
                                state     <= DONE;
                                arr_valid <= 1'b0;
                                out_valid <= 1'b1;
                            end
                        end else begin
                            state    <= WR_LO;
                            arr_addr <= lo;
                            arr_we   <= 1'b1;
                            arr_di   <= arr_do;
                        end
`else
                        // arr_di doubles as the tmp_hi holding register.
                        state    <= WR_LO;
                        arr_addr <= lo;
                        arr_we   <= 1'b1;
                        arr_di   <= arr_do;
`endif
                    end
                end

                WR_LO: begin
                    if (xfer) begin
                        state    <= WR_HI;
                        arr_addr <= hi;
                        arr_di   <= tmp_lo;
                    end
                end

                WR_HI: begin
                    if (xfer) begin
                        swaps  <= swaps + AW'(1);
                        lo     <= lo_nxt;
                        hi     <= hi_nxt;
                        arr_we <= 1'b0;
                        if (more) begin
                            state    <= RD_LO;
                            arr_addr <= lo_nxt;
                        end else begin
                            state     <= DONE;
                            arr_valid <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    arr_valid <= 1'b0;
                    arr_we    <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_reverse.sv
module tb_array_reverse;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_lo;
    logic [AW-1:0] in_hi;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_swaps;
    logic          arr_valid;
    logic          arr_ready;
    logic [AW-1:0] arr_addr;
    logic          arr_we;
    logic [DW-1:0] arr_di;
    logic [DW-1:0] arr_do;

    always #5 clk = ~clk;

    array_reverse #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready), .in_lo(in_lo), .in_hi(in_hi),
        .out_valid(out_valid), .out_ready(out_ready), .out_swaps(out_swaps),
        .arr_valid(arr_valid), .arr_ready(arr_ready), .arr_addr(arr_addr),
        .arr_we(arr_we), .arr_di(arr_di), .arr_do(arr_do)
    );

    // Array model: combinational read, write at the completing edge.
    logic [DW-1:0] mem      [N];
    logic [DW-1:0] init_mem [N];
    logic [DW-1:0] exp_mem  [N];
    assign arr_do = mem[arr_addr];

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int exp_swaps;
    int exp_pairs;
    bit rand_ready = 1'b0;

    bit            stall_prev = 1'b0;
    logic [AW-1:0] h_addr;
    logic          h_we;
    logic [DW-1:0] h_di;

    always @(posedge clk) begin
        if (nrst && stall_prev && arr_valid) begin
            total++;
            if (arr_addr !== h_addr || arr_we !== h_we || arr_di !== h_di) begin
                bad++;
                $display("FAIL stall_hold got addr=%0d we=%0b di=%h want addr=%0d we=%0b di=%h",
                         arr_addr, arr_we, arr_di, h_addr, h_we, h_di);
            end
        end
        stall_prev = nrst && arr_valid && !arr_ready;
        h_addr = arr_addr;
        h_we   = arr_we;
        h_di   = arr_di;
        if (nrst && arr_valid && arr_ready) begin
            if (arr_we) begin
                mem[arr_addr] = arr_di;
                wr_cnt++;
            end else begin
                rd_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            arr_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic preload(input bit rnd);
        for (int i = 0; i < N; i++) begin
            init_mem[i] = rnd ? DW'($urandom_range(0, 3)) : DW'(i);
            mem[i] = init_mem[i];
        end
    endtask

    // Reference: region mirrored around its centre; a pair counts as a swap
    // unless it is skipped for already-equal values.
    task automatic build_ref(input int lo, input int hi);
        int a;
        int b;
        for (int i = 0; i < N; i++)
            exp_mem[i] = (lo < hi && i >= lo && i <= hi) ? init_mem[lo + hi - i] : init_mem[i];
        exp_swaps = 0;
        exp_pairs = 0;
        a = lo;
        b = hi;
        while (a < b) begin
            exp_pairs++;
`ifdef ARRAY_REVERSE_SKIP_EQ_EN
            if (init_mem[a] != init_mem[b]) exp_swaps++;
`else
            exp_swaps++;
`endif
            a++;
            b--;
        end
    endtask

    task automatic check_mem(input string name);
        int errs;
        int first;
        errs = 0;
        first = -1;
        for (int i = 0; i < N; i++)
            if (mem[i] !== exp_mem[i]) begin
                errs++;
                if (first < 0) first = i;
            end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s wrong_cells=%0d first_idx=%0d got=%0d want=%0d",
                     name, errs, first, mem[first], exp_mem[first]);
        end
    endtask

    // Called just after an edge with the DUT idle; returns the cycle (counted
    // from the accept cycle = 0) at which out_valid is first seen.
    task automatic run_cmd(input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                           input int budget, output int cyc);
        rd_cnt = 0;
        wr_cnt = 0;
        in_lo = lo;
        in_hi = hi;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL timeout lo=%0d hi=%0d got=no_out_valid want=out_valid", lo, hi);
        end
    endtask

    task automatic finish_out();
        @(posedge clk); #1;
        check("idle_after_out", {31'd0, in_ready}, 1);
    endtask

    typedef struct {
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
        int            swaps;
        int            cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog got=no_finish want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{lo: 4'd0,  hi: 4'd15, swaps: 8, cyc: 33};
        vecs[1] = '{lo: 4'd5,  hi: 4'd5,  swaps: 0, cyc: 1};
        vecs[2] = '{lo: 4'd9,  hi: 4'd3,  swaps: 0, cyc: 1};
        vecs[3] = '{lo: 4'd3,  hi: 4'd4,  swaps: 1, cyc: 5};
        vecs[4] = '{lo: 4'd0,  hi: 4'd1,  swaps: 1, cyc: 5};
        vecs[5] = '{lo: 4'd6,  hi: 4'd10, swaps: 2, cyc: 9};
        vecs[6] = '{lo: 4'd14, hi: 4'd15, swaps: 1, cyc: 5};
        vecs[7] = '{lo: 4'd0,  hi: 4'd14, swaps: 7, cyc: 29};

        in_valid = 1'b0;
        in_lo = '0;
        in_hi = '0;
        out_ready = 1'b1;
        arr_ready = 1'b1;
        preload(1'b0);
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_arr_valid", {31'd0, arr_valid}, 0);
        check("rst_arr_we", {31'd0, arr_we}, 0);
        check("rst_arr_addr", arr_addr, 0);
        check("rst_arr_di", arr_di, 0);
        check("rst_out_swaps", out_swaps, 0);
        @(posedge clk); #1;

        // Directed table, arr_ready held high, distinct data.
        foreach (vecs[v]) begin
            preload(1'b0);
            build_ref(vecs[v].lo, vecs[v].hi);
            run_cmd(vecs[v].lo, vecs[v].hi, 200, cyc);
            check($sformatf("tab%0d_latency", v), cyc, vecs[v].cyc);
            check($sformatf("tab%0d_swaps", v), out_swaps, vecs[v].swaps);
            check($sformatf("tab%0d_reads", v), rd_cnt, 2 * vecs[v].swaps);
            check($sformatf("tab%0d_writes", v), wr_cnt, 2 * vecs[v].swaps);
            check_mem($sformatf("tab%0d_mem", v));
            finish_out();
        end

        // Region 2..13 under a stalling array.
        preload(1'b0);
        build_ref(2, 13);
        rand_ready = 1'b1;
        run_cmd(4'd2, 4'd13, 1000, cyc);
        check("stall_swaps", out_swaps, 6);
        check_mem("stall_mem");
        finish_out();
        rand_ready = 1'b0;
        @(posedge clk); #2;
        arr_ready = 1'b1;

        // Result back-pressure: DONE holds, commands ignored.
        preload(1'b0);
        build_ref(3, 4);
        out_ready = 1'b0;
        run_cmd(4'd3, 4'd4, 200, cyc);
        for (int k = 0; k < 10; k++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_lo = 4'd0;
            in_hi = 4'd15;
            @(posedge clk); #1;
            check($sformatf("hold%0d_vld_rdy_swp", k),
                  out_valid * 100 + in_ready * 10 + out_swaps, 101);
        end
        in_valid = 1'b0;
        check("hold_no_array_traffic", rd_cnt + wr_cnt, 4);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_out_valid", {31'd0, out_valid}, 0);
        check("hold_release_in_ready", {31'd0, in_ready}, 1);
        check_mem("hold_mem");

        // Reset in the cycle after the WR_LO write of pair (2,5).
        preload(1'b0);
        rd_cnt = 0;
        wr_cnt = 0;
        in_lo = 4'd2;
        in_hi = 4'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        check("abort_arr_valid", {31'd0, arr_valid}, 0);
        check("abort_out_valid", {31'd0, out_valid}, 0);
        check("abort_arr_we_addr_di", arr_we + arr_addr + arr_di, 0);
        check("abort_out_swaps", out_swaps, 0);
        check("abort_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        nrst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_data2", mem[2], 5);
        check("abort_data5", mem[5], 5);
        check("abort_data3", mem[3], 3);
        check("abort_writes", wr_cnt, 1);
        check("abort_reads", rd_cnt, 2);

        // Equal pair.
        preload(1'b0);
        init_mem[0] = 16'd7;
        init_mem[1] = 16'd7;
        mem[0] = 16'd7;
        mem[1] = 16'd7;
        build_ref(0, 1);
        run_cmd(4'd0, 4'd1, 200, cyc);
        check("eq_reads", rd_cnt, 2);
`ifdef ARRAY_REVERSE_SKIP_EQ_EN
        check("eq_writes", wr_cnt, 0);
        check("eq_swaps", out_swaps, 0);
        check("eq_latency", cyc, 3);
`else
        check("eq_writes", wr_cnt, 2);
        check("eq_swaps", out_swaps, 1);
        check("eq_latency", cyc, 5);
`endif
        check_mem("eq_mem");
        finish_out();

        // Random regions, small-alphabet data, stalling array.
        rand_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            logic [AW-1:0] rlo;
            logic [AW-1:0] rhi;
            rlo = AW'($urandom_range(0, N - 1));
            rhi = AW'($urandom_range(0, N - 1));
            preload(1'b1);
            build_ref(rlo, rhi);
            run_cmd(rlo, rhi, 2000, cyc);
            check($sformatf("rnd%0d_swaps", t), out_swaps, exp_swaps);
            check($sformatf("rnd%0d_reads", t), rd_cnt, 2 * exp_pairs);
            check($sformatf("rnd%0d_writes", t), wr_cnt, 2 * exp_swaps);
            check_mem($sformatf("rnd%0d_mem", t));
            finish_out();
        end
        rand_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
